// File: rtl/sonar_rx_comandos.sv
// Serial command receiver for the sonar: deserialises 7O2 UART frames and turns
// single ASCII characters into ligar / interromper / reset_sistema controls for sonar_uc.
module sonar_rx_comandos #(
  parameter int unsigned DIVISOR = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       ligar,
  output logic       interromper,
  output logic       reset_sistema,
  output logic       comando_invalido,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_quadro,
  output logic [6:0] dado_recebido,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = $clog2(DIVISOR);
  localparam logic [TW-1:0] FIM_BIT  = TW'(DIVISOR - 1);
  localparam logic [TW-1:0] FIM_MEIO = TW'(DIVISOR / 2 - 1);

  typedef enum logic [3:0] {
    REPOUSO    = 4'd0,
    START      = 4'd1,
    DADOS      = 4'd2,
    PARIDADE   = 4'd3,
    STOP       = 4'd4,
    DECODIFICA = 4'd5,
    ERRO       = 4'd6
  } estado_t;

  estado_t       estado, prox;
  logic          rx_m, rx_s;
  logic [TW-1:0] tmr;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift;
  logic          pbit;
  logic          tmr_fim;
  logic          paridade_ok;
  logic          em_decod;
  logic          cmd_l, cmd_p, cmd_c, cmd_r;

  // The start state times only half a bit so later samples land mid-bit.
  assign tmr_fim     = (estado == START) ? (tmr == FIM_MEIO) : (tmr == FIM_BIT);
  assign paridade_ok = ^{shift, pbit};
  assign em_decod    = (estado == DECODIFICA);
  assign db_estado   = estado;

  assign cmd_l = (shift == 7'h6C) || (shift == 7'h4C);
  assign cmd_p = (shift == 7'h70) || (shift == 7'h50);
  assign cmd_c = (shift == 7'h63) || (shift == 7'h43);
  assign cmd_r = (shift == 7'h72) || (shift == 7'h52);

  always_comb begin
    prox = estado;
    case (estado)
      REPOUSO:    if (!rx_s) prox = START;
      START:      if (tmr_fim) prox = rx_s ? REPOUSO : DADOS;
      DADOS:      if (tmr_fim && bit_cnt == 3'd6) prox = PARIDADE;
      PARIDADE:   if (tmr_fim) prox = STOP;
      STOP:       if (tmr_fim) prox = rx_s ? DECODIFICA : ERRO;
      DECODIFICA: prox = REPOUSO;
      ERRO:       if (rx_s) prox = REPOUSO;
      default:    prox = REPOUSO;
    endcase
  end

  always_comb begin
    pronto           = 1'b0;
    ligar            = 1'b0;
    reset_sistema    = 1'b0;
    comando_invalido = 1'b0;
    erro_quadro      = (estado == ERRO);
    if (em_decod) begin
      pronto = 1'b1;
      if (paridade_ok) begin
        ligar            = cmd_l;
        reset_sistema    = cmd_r;
        comando_invalido = !(cmd_l || cmd_p || cmd_c || cmd_r);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      estado        <= REPOUSO;
      tmr           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      pbit          <= 1'b0;
      dado_recebido <= '0;
      erro_paridade <= 1'b0;
      interromper   <= 1'b0;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      estado <= prox;

      if (estado != prox || estado == REPOUSO || tmr_fim)
        tmr <= '0;
      else
        tmr <= tmr + TW'(1);

      if (estado == REPOUSO)
        bit_cnt <= '0;
      else if (estado == DADOS && tmr_fim)
        bit_cnt <= bit_cnt + 3'd1;

      if (estado == DADOS && tmr_fim)
        shift <= {rx_s, shift[6:1]};

      if (estado == PARIDADE && tmr_fim)
        pbit <= rx_s;

      if (em_decod) begin
        dado_recebido <= shift;
        erro_paridade <= ~paridade_ok;
        if (paridade_ok) begin
          if (cmd_p)
            interromper <= 1'b1;
          else if (cmd_c || cmd_r)
            interromper <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_rx_comandos.sv
// Self-checking bench for sonar_rx_comandos: directed 7O2 frames plus random frames
// checked against a character-level model of the command decoder.
module tb_sonar_rx_comandos;

  localparam int unsigned D = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       ligar, interromper, reset_sistema, comando_invalido;
  logic       pronto, erro_paridade, erro_quadro;
  logic [6:0] dado_recebido;
  logic [3:0] db_estado;

  sonar_rx_comandos #(.DIVISOR(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .rx              (rx),
    .ligar           (ligar),
    .interromper     (interromper),
    .reset_sistema   (reset_sistema),
    .comando_invalido(comando_invalido),
    .pronto          (pronto),
    .erro_paridade   (erro_paridade),
    .erro_quadro     (erro_quadro),
    .dado_recebido   (dado_recebido),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pronto_cyc = 0;
  int n_pronto = 0, n_ligar = 0, n_rs = 0, n_inv = 0;
  bit seen_start = 0;

  logic       m_int  = 1'b0;
  logic [6:0] m_dado = '0;
  logic       m_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor samples 1 time unit after each rising edge.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (pronto) begin
      n_pronto++;
      pronto_cyc = cyc;
    end
    if (ligar) n_ligar++;
    if (reset_sistema) n_rs++;
    if (comando_invalido) n_inv++;
    if (db_estado == 4'd1) seen_start = 1;
    if (ligar || reset_sistema || comando_invalido)
      check("pulse_with_pronto", pronto, 1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic par_odd(input logic [6:0] c);
    return ($countones(c) % 2) == 0;
  endfunction

  // Drives start, 7 data bits, parity and first stop bit; entered and left on a falling edge.
  task automatic send_bits(input logic [6:0] c, input logic p, input logic s1);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (D) @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      rx = c[i];
      repeat (D) @(negedge clock);
    end
    rx = p;
    repeat (D) @(negedge clock);
    rx = s1;
    repeat (D) @(negedge clock);
  endtask

  task automatic frame(input logic [6:0] c, input logic p);
    int  p0, l0, r0, i0;
    bit  ok;
    int  el, er, ei;
    p0 = n_pronto; l0 = n_ligar; r0 = n_rs; i0 = n_inv;
    send_bits(c, p, 1'b1);
    rx = 1'b1;
    repeat (D) @(negedge clock);

    ok = ($countones({c, p}) % 2) == 1;
    el = 0; er = 0; ei = 0;
    if (ok) begin
      case ({1'b0, c})
        "l", "L": el = 1;
        "p", "P": m_int = 1'b1;
        "c", "C": m_int = 1'b0;
        "r", "R": begin er = 1; m_int = 1'b0; end
        default:  ei = 1;
      endcase
    end
    m_dado = c;
    m_perr = !ok;

    check("pronto_count", n_pronto - p0, 1);
    check("ligar_count", n_ligar - l0, el);
    check("reset_sistema_count", n_rs - r0, er);
    check("invalido_count", n_inv - i0, ei);
    check("dado_recebido", dado_recebido, m_dado);
    check("erro_paridade", erro_paridade, m_perr);
    check("interromper", interromper, m_int);
    check("latency_ok", (pronto_cyc - start_cyc >= 78) && (pronto_cyc - start_cyc <= 80), 1);
    check("idle_state", db_estado, 0);
  endtask

  initial begin
    int         p0;
    logic [6:0] c;
    logic       p;
    byte        b;
    string      cmds;

    // Reset with line idle
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_estado", db_estado, 0);
    check("rst_pulses", {ligar, reset_sistema, comando_invalido, pronto}, 0);
    check("rst_levels", {interromper, erro_paridade, erro_quadro}, 0);
    check("rst_dado", dado_recebido, 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_after_rst", db_estado, 0);

    frame(7'h6C, 1'b1);          // 'l'
    frame(7'h70, 1'b0);          // 'p'
    frame(7'h63, 1'b1);          // 'c'
    frame(7'h6C, 1'b0);          // 'l' with bad parity
    frame(7'h78, 1'b1);          // 'x'

    // Short glitch on the line
    seen_start = 0;
    p0 = n_pronto;
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (12) @(negedge clock);
    check("glitch_seen_start", seen_start, 1);
    check("glitch_no_pronto", n_pronto - p0, 0);
    check("glitch_idle", db_estado, 0);

    // Framing error: first stop bit low
    p0 = n_pronto;
    send_bits(7'h6C, 1'b1, 1'b0);
    check("fe_estado", db_estado, 6);
    check("fe_erro_quadro", erro_quadro, 1);
    repeat (2 * D) @(negedge clock);
    check("fe_hold", erro_quadro, 1);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check("fe_exit_estado", db_estado, 0);
    check("fe_exit_erro_quadro", erro_quadro, 0);
    check("fe_no_pronto", n_pronto - p0, 0);
    check("fe_dado_kept", dado_recebido, m_dado);
    check("fe_perr_kept", erro_paridade, m_perr);
    repeat (D) @(negedge clock);

    // Back-to-back 'p' then 'r'
    frame(7'h70, 1'b0);
    frame(7'h72, par_odd(7'h72));

    // Reset in the middle of the data bits
    frame(7'h50, par_odd(7'h50)); // 'P'
    p0 = n_pronto;
    rx = 1'b0;
    repeat (D) @(negedge clock);
    rx = 1'b0;
    repeat (D) @(negedge clock);
    rx = 1'b1;
    repeat (D) @(negedge clock);
    check("mid_in_dados", db_estado, 2);
    reset = 1'b0;
    @(negedge clock);
    m_int = 1'b0;
    m_dado = '0;
    m_perr = 1'b0;
    check("mid_rst_estado", db_estado, 0);
    check("mid_rst_interromper", interromper, 0);
    check("mid_rst_dado", dado_recebido, 0);
    reset = 1'b1;
    rx = 1'b1;
    repeat (12 * D) @(negedge clock);
    check("mid_no_pronto", n_pronto - p0, 0);
    check("mid_idle", db_estado, 0);

    // Random frames, mostly commands, some with bad parity
    cmds = "lLpPcCrR";
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        b = cmds[$urandom_range(7, 0)];
        c = b[6:0];
      end else begin
        c = 7'($urandom);
      end
      p = par_odd(c);
      if ($urandom_range(3, 0) == 0) p = ~p;
      frame(c, p);
      repeat ($urandom_range(2, 0) * D) @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
